// File: rtl/game_pkg.sv
// Shared screen/sprite constants and enemy state encoding for the gameplay logic.
package game_pkg;

  localparam int COORD_W = 12;
  localparam int X_W     = 11;
  localparam int Y_W     = 10;
  localparam int HP_W    = 4;

  localparam int DEF_BULLET_W = 16;
  localparam int DEF_BULLET_H = 8;
  localparam int DEF_ENEMY_W  = 64;
  localparam int DEF_ENEMY_H  = 96;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VULN   = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } enemy_state_e;

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned box overlap; edges that only touch do not count.
module box_overlap
  import game_pkg::*;
#(
  parameter int A_W = DEF_BULLET_W,
  parameter int A_H = DEF_BULLET_H,
  parameter int B_W = DEF_ENEMY_W,
  parameter int B_H = DEF_ENEMY_H
) (
  input  logic [X_W-1:0] x_a,
  input  logic [Y_W-1:0] y_a,
  input  logic [X_W-1:0] x_b,
  input  logic [Y_W-1:0] y_b,
  output logic           overlap
);

  // One extra bit of headroom keeps coordinate + size from wrapping.
  logic [COORD_W-1:0] xa, ya, xb, yb;

  assign xa = COORD_W'(x_a);
  assign ya = COORD_W'(y_a);
  assign xb = COORD_W'(x_b);
  assign yb = COORD_W'(y_b);

  assign overlap = (xa < xb + COORD_W'(B_W)) &&
                   (xb < xa + COORD_W'(A_W)) &&
                   (ya < yb + COORD_W'(B_H)) &&
                   (yb < ya + COORD_W'(A_H));

endmodule

// File: rtl/bullet_hit_judge.sv
// Judges bullet/enemy hits, tracks enemy HP and runs the invulnerability/death FSM.
//   state  | meaning
//   IDLE   | before the first round; no judging
//   VULN   | enemy can be hit or block
//   INVULN | post-hit grace window, timer running
//   DEAD   | HP exhausted, waits for restart
module bullet_hit_judge
  import game_pkg::*;
#(
  parameter int BULLET_W   = DEF_BULLET_W,
  parameter int BULLET_H   = DEF_BULLET_H,
  parameter int ENEMY_W    = DEF_ENEMY_W,
  parameter int ENEMY_H    = DEF_ENEMY_H,
  parameter int HP_MAX     = 10,
  parameter int DMG        = 1,
  parameter int INVULN_CYC = 25_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            active,
  input  logic            restart,
  input  logic [X_W-1:0]  xBullet,
  input  logic [Y_W-1:0]  yBullet,
  input  logic            isEBullet,
  input  logic [X_W-1:0]  xEnemy,
  input  logic [Y_W-1:0]  yEnemy,
  input  logic            enemyDefend,
  output logic            hitPulse,
  output logic            blockPulse,
  output logic [HP_W-1:0] hp,
  output logic            invuln,
  output logic            dead
);

  localparam int                TMR_W    = $clog2(INVULN_CYC);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(INVULN_CYC - 1);
  localparam logic [HP_W-1:0]   HP_INIT  = HP_W'(HP_MAX);

  enemy_state_e      state, state_nxt;
  logic [HP_W-1:0]   hp_r, hp_nxt, hp_dmg;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic              armed, armed_nxt;
  logic              ovl_r, overlap;
  logic              hit_r, hit_nxt;
  logic              block_r, block_nxt;
  logic              judge;

  box_overlap #(
    .A_W (BULLET_W),
    .A_H (BULLET_H),
    .B_W (ENEMY_W),
    .B_H (ENEMY_H)
  ) u_overlap (
    .x_a     (xBullet),
    .y_a     (yBullet),
    .x_b     (xEnemy),
    .y_b     (yEnemy),
    .overlap (overlap)
  );

  assign judge  = ovl_r & armed & active;
  assign hp_dmg = (int'(hp_r) > DMG) ? hp_r - HP_W'(DMG) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hp_r    <= HP_INIT;
      timer   <= '0;
      armed   <= 1'b1;
      ovl_r   <= 1'b0;
      hit_r   <= 1'b0;
      block_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      hp_r    <= hp_nxt;
      timer   <= timer_nxt;
      armed   <= armed_nxt;
      ovl_r   <= overlap & isEBullet;
      hit_r   <= hit_nxt;
      block_r <= block_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hp_nxt    = hp_r;
    timer_nxt = timer;
    hit_nxt   = 1'b0;
    block_nxt = 1'b0;

    if (restart) begin
      state_nxt = VULN;
      hp_nxt    = HP_INIT;
      timer_nxt = '0;
    end else begin
      case (state)
        VULN: begin
          if (judge) begin
            if (enemyDefend) begin
              block_nxt = 1'b1;
            end else begin
              hit_nxt = 1'b1;
              hp_nxt  = hp_dmg;
              if (hp_dmg == '0) begin
                state_nxt = DEAD;
              end else begin
                state_nxt = INVULN;
                timer_nxt = TMR_LOAD;
              end
            end
          end
        end
        INVULN: begin
          if (active) begin
            if (timer == '0) state_nxt = VULN;
            else             timer_nxt = timer - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A new flight (bullet gone) re-arms; any overlap seen while judging disarms.
  always_comb begin
    armed_nxt = armed;
    if (restart || !isEBullet)
      armed_nxt = 1'b1;
    else if (ovl_r && active && (state == VULN || state == INVULN))
      armed_nxt = 1'b0;
  end

  assign hitPulse   = hit_r;
  assign blockPulse = block_r;
  assign hp         = hp_r;
  assign invuln     = (state == INVULN);
  assign dead       = (state == DEAD);

endmodule

// File: tb/tb_bullet_hit_judge.sv
// Directed scenarios plus randomized play for bullet_hit_judge against a cycle-level reference model.
module tb_bullet_hit_judge;

  localparam int BW = 16, BH = 8, EW = 64, EH = 96;
  localparam int INV_CYC = 8;
  localparam int S_IDLE = 0, S_VULN = 1, S_INV = 2, S_DEAD = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        active = 1'b1;
  logic        restart = 1'b0;
  logic [10:0] xb = '0, xe = '0;
  logic [9:0]  yb = '0, ye = '0;
  logic        is_e = 1'b0;
  logic        def = 1'b0;

  logic       hit_a, blk_a, inv_a, dead_a;
  logic       hit_b, blk_b, inv_b, dead_b;
  logic [3:0] hp_a, hp_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bullet_hit_judge #(.HP_MAX(10), .DMG(1), .INVULN_CYC(INV_CYC)) u_a (
    .clk(clk), .rst_n(rst_n), .active(active), .restart(restart),
    .xBullet(xb), .yBullet(yb), .isEBullet(is_e),
    .xEnemy(xe), .yEnemy(ye), .enemyDefend(def),
    .hitPulse(hit_a), .blockPulse(blk_a), .hp(hp_a), .invuln(inv_a), .dead(dead_a)
  );

  bullet_hit_judge #(.HP_MAX(2), .DMG(3), .INVULN_CYC(INV_CYC)) u_b (
    .clk(clk), .rst_n(rst_n), .active(active), .restart(restart),
    .xBullet(xb), .yBullet(yb), .isEBullet(is_e),
    .xEnemy(xe), .yEnemy(ye), .enemyDefend(def),
    .hitPulse(hit_b), .blockPulse(blk_b), .hp(hp_b), .invuln(inv_b), .dead(dead_b)
  );

  // Reference model: one entry per instance.
  int hpmax[2] = '{10, 2};
  int dmg[2]   = '{1, 3};
  int m_state[2], m_hp[2], m_rem[2], m_armed[2], m_ovl[2], m_hit[2], m_blk[2];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit boxes_touch(int bx, int by, int ex, int ey);
    return (bx < ex + EW) && (ex < bx + BW) && (by < ey + EH) && (ey < by + BH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = S_IDLE; m_hp[i] = hpmax[i]; m_rem[i] = 0;
      m_armed[i] = 1; m_ovl[i] = 0; m_hit[i] = 0; m_blk[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int st = m_state[i];
      bit ev = m_ovl[i] && m_armed[i] && active && (st == S_VULN);
      if (restart || !is_e) m_armed[i] = 1;
      else if (m_ovl[i] && active && (st == S_VULN || st == S_INV)) m_armed[i] = 0;
      m_hit[i] = 0;
      m_blk[i] = 0;
      if (restart) begin
        m_state[i] = S_VULN; m_hp[i] = hpmax[i]; m_rem[i] = 0;
      end else if (ev) begin
        if (def) m_blk[i] = 1;
        else begin
          m_hit[i] = 1;
          m_hp[i] = (m_hp[i] > dmg[i]) ? m_hp[i] - dmg[i] : 0;
          if (m_hp[i] == 0) m_state[i] = S_DEAD;
          else begin m_state[i] = S_INV; m_rem[i] = INV_CYC; end
        end
      end else if (st == S_INV && active) begin
        m_rem[i]--;
        if (m_rem[i] == 0) m_state[i] = S_VULN;
      end
      m_ovl[i] = boxes_touch(int'(xb), int'(yb), int'(xe), int'(ye)) && is_e;
    end
  endtask

  task automatic compare_all();
    check("a_hp", int'(hp_a), m_hp[0]);
    check("a_hit", int'(hit_a), m_hit[0]);
    check("a_blk", int'(blk_a), m_blk[0]);
    check("a_inv", int'(inv_a), int'(m_state[0] == S_INV));
    check("a_dead", int'(dead_a), int'(m_state[0] == S_DEAD));
    check("b_hp", int'(hp_b), m_hp[1]);
    check("b_hit", int'(hit_b), m_hit[1]);
    check("b_blk", int'(blk_b), m_blk[1]);
    check("b_inv", int'(inv_b), int'(m_state[1] == S_INV));
    check("b_dead", int'(dead_b), int'(m_state[1] == S_DEAD));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hp_a"}, int'(hp_a), 10);
    check({tag, "_hp_b"}, int'(hp_b), 2);
    check({tag, "_hit_a"}, int'(hit_a), 0);
    check({tag, "_blk_a"}, int'(blk_a), 0);
    check({tag, "_inv_a"}, int'(inv_a), 0);
    check({tag, "_dead_a"}, int'(dead_a), 0);
    check({tag, "_hit_b"}, int'(hit_b), 0);
    check({tag, "_dead_b"}, int'(dead_b), 0);
  endtask

  initial begin
    int hits;
    int x, y;

    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;

    // restart from IDLE
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick();

    // first hit: pulse two edges after the inputs
    xb = 11'd100; yb = 10'd200; xe = 11'd90; ye = 10'd180; is_e = 1'b1;
    tick();
    check("s1_no_early_hit", int'(hit_a), 0);
    tick();
    check("s1_hit", int'(hit_a), 1);
    check("s1_hp", int'(hp_a), 9);
    check("s1_inv", int'(inv_a), 1);
    check("s1_b_hp", int'(hp_b), 0);
    check("s1_b_dead", int'(dead_b), 1);

    // bullet keeps flying through the enemy
    hits = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      hits += int'(hit_a);
    end
    check("s2_extra_hits", hits, 0);
    check("s2_b_no_hit", int'(hit_b), 0);
    is_e = 1'b0;
    tick();
    is_e = 1'b1;
    tick();
    tick();
    check("s2_rehit", int'(hit_a), 1);
    check("s2_hp", int'(hp_a), 8);

    // touching edges on both x sides
    is_e = 1'b0;
    repeat (10) tick();
    check("s3_vuln", int'(inv_a), 0);
    xb = 11'd154; is_e = 1'b1;
    repeat (3) tick();
    xb = 11'd74;
    repeat (3) tick();
    xb = 11'd100; yb = 10'd276;
    repeat (3) tick();
    check("s3_hp", int'(hp_a), 8);
    check("s3_nohit", int'(hit_a), 0);

    // blocked hit
    is_e = 1'b0;
    yb = 10'd200; def = 1'b1;
    tick();
    is_e = 1'b1;
    tick();
    tick();
    check("s4_blk", int'(blk_a), 1);
    check("s4_hit", int'(hit_a), 0);
    check("s4_hp", int'(hp_a), 8);
    check("s4_vuln", int'(inv_a), 0);
    def = 1'b0;
    tick();
    check("s4_blk_once", int'(blk_a), 0);

    // restart coinciding with an armed overlap
    is_e = 1'b0;
    tick();
    is_e = 1'b1;
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("s5_b_hp", int'(hp_b), 2);
    check("s5_b_alive", int'(dead_b), 0);
    check("s5_b_nohit", int'(hit_b), 0);
    check("s5_a_hp", int'(hp_a), 10);
    check("s5_a_nohit", int'(hit_a), 0);
    tick();
    check("s5_a_inv", int'(inv_a), 1);

    // async reset mid-INVULN
    #2 rst_n = 1'b0;
    #1 check_reset_values("mid_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_reset_values("rst_hold");
    rst_n = 1'b1;
    is_e = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;

    // randomized play
    for (int n = 0; n < 3000; n++) begin
      active  = ($urandom % 8) != 0;
      restart = ($urandom % 64) == 0;
      def     = ($urandom % 4) == 0;
      if (($urandom % 6) == 0) is_e = ~is_e;
      if (($urandom % 32) == 0) begin
        xe = 11'($urandom_range(0, 1900));
        ye = 10'($urandom_range(0, 900));
      end
      if (($urandom % 4) == 0) begin
        x = int'(xe) + int'($urandom_range(0, 110)) - 30;
        y = int'(ye) + int'($urandom_range(0, 120)) - 20;
        if (x < 0) x = 0;
        if (x > 2047) x = 2047;
        if (y < 0) y = 0;
        if (y > 1023) y = 1023;
        xb = 11'(x);
        yb = 10'(y);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
